// File: rtl/circ_buf_pkg.sv
// Constants and forwarder state type shared by the reorder path
// (tag forwarder and circular buffer).
package circ_buf_pkg;
  localparam int TAG_WIDTH            = 6;
  localparam int CIRCULAR_BUFFER_SIZE = 50;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DROP    = 2'd2
  } fwd_state_e;
endpackage

// File: rtl/reorder_tag_forwarder_if.sv
// Stream bundle of the tag forwarder: ingress, buffer copy and shared core bus.
// slave = forwarder side, master = the surrounding ingress/buffer/cores.
interface reorder_tag_forwarder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 6,
  parameter int N_CORES    = 4
);
  logic [DATA_WIDTH-1:0]   in_TDATA;
  logic [DATA_WIDTH/8-1:0] in_TKEEP;
  logic                    in_TLAST;
  logic                    in_TVALID;
  logic                    in_TREADY;

  logic [DATA_WIDTH-1:0]   buf_TDATA;
  logic [DATA_WIDTH/8-1:0] buf_TKEEP;
  logic                    buf_TLAST;
  logic                    buf_TVALID;
  logic [TAG_WIDTH-1:0]    buf_reorder_tag;
  logic                    buf_TREADY;

  logic [DATA_WIDTH-1:0]   core_TDATA;
  logic [DATA_WIDTH/8-1:0] core_TKEEP;
  logic                    core_TLAST;
  logic [TAG_WIDTH-1:0]    core_reorder_tag;
  logic [N_CORES-1:0]      core_TVALID;
  logic [N_CORES-1:0]      core_TREADY;

  modport slave (
    input  in_TDATA, in_TKEEP, in_TLAST, in_TVALID, buf_TREADY, core_TREADY,
    output in_TREADY, buf_TDATA, buf_TKEEP, buf_TLAST, buf_TVALID, buf_reorder_tag,
           core_TDATA, core_TKEEP, core_TLAST, core_reorder_tag, core_TVALID
  );

  modport master (
    output in_TDATA, in_TKEEP, in_TLAST, in_TVALID, buf_TREADY, core_TREADY,
    input  in_TREADY, buf_TDATA, buf_TKEEP, buf_TLAST, buf_TVALID, buf_reorder_tag,
           core_TDATA, core_TKEEP, core_TLAST, core_reorder_tag, core_TVALID
  );
endinterface

// File: rtl/rr_core_select.sv
// Round-robin pick: first ready core at or above ptr, wrapping around.
module rr_core_select #(
  parameter int N_CORES = 4,
  parameter int RR_W    = 2
) (
  input  logic [N_CORES-1:0] ready,
  input  logic [RR_W-1:0]    ptr,
  output logic               found,
  output logic [RR_W-1:0]    idx
);
  logic [2*N_CORES-1:0] dbl;
  logic [N_CORES-1:0]   rot;
  logic [RR_W-1:0]      off;
  logic [RR_W:0]        sum;

  always_comb begin
    dbl   = {ready, ready} >> ptr;
    rot   = dbl[N_CORES-1:0];
    found = 1'b0;
    off   = '0;
    // descending scan so the smallest offset from ptr wins
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = RR_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (RR_W+1)'(N_CORES)) sum = sum - (RR_W+1)'(N_CORES);
    idx = sum[RR_W-1:0];
  end
endmodule

// File: rtl/reorder_tag_forwarder.sv
// Tags ingress packets, broadcasts them to the reorder buffer and a round-robin
// filter core, and throttles on buffer credit. FORWARDER_TRUNCATE_EN enables length cap.
module reorder_tag_forwarder
  import circ_buf_pkg::*;
#(
  parameter int TAG_WIDTH            = circ_buf_pkg::TAG_WIDTH,
  parameter int CIRCULAR_BUFFER_SIZE = circ_buf_pkg::CIRCULAR_BUFFER_SIZE,
  parameter int DATA_WIDTH           = 64,
  parameter int N_CORES              = 4,
  parameter int MAX_TDATA_PER_PACKET = 375,
  localparam int OUT_W               = $clog2(CIRCULAR_BUFFER_SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  reorder_tag_forwarder_if.slave    bus,
  input  logic                      tag_retire,
  output logic [OUT_W-1:0]          outstanding
);
  localparam int RR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  fwd_state_e           state_q, state_d;
  logic [TAG_WIDTH-1:0] cur_tag_q, cur_tag_d;
  logic [TAG_WIDTH-1:0] next_tag_q, next_tag_d;
  logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [RR_W-1:0]      sel_q, sel_d;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;

  logic               sel_found, sel_rdy, alloc, retire, xfer, trunc;
  logic [RR_W-1:0]    sel_idx;
  logic               in_rdy, buf_vld;
  logic [N_CORES-1:0] core_vld;

`ifdef FORWARDER_TRUNCATE_EN
  localparam int BC_W = $clog2(MAX_TDATA_PER_PACKET + 1);
  logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
`endif

  rr_core_select #(.N_CORES(N_CORES), .RR_W(RR_W)) u_rr_core_select (
    .ready (bus.core_TREADY),
    .ptr   (rr_ptr_q),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_comb begin
    state_d    = state_q;
    cur_tag_d  = cur_tag_q;
    next_tag_d = next_tag_q;
    rr_ptr_d   = rr_ptr_q;
    sel_d      = sel_q;
    in_rdy     = 1'b0;
    buf_vld    = 1'b0;
    core_vld   = '0;
    trunc      = 1'b0;
    xfer       = 1'b0;
`ifdef FORWARDER_TRUNCATE_EN
    beat_cnt_d = beat_cnt_q;
`endif
    sel_rdy = bus.core_TREADY[sel_q];
    alloc   = (state_q == IDLE) && bus.in_TVALID && sel_found &&
              (outstanding_q < OUT_W'(CIRCULAR_BUFFER_SIZE));
    retire  = tag_retire && (outstanding_q != '0);

    case (state_q)
      IDLE: begin
        if (alloc) begin
          state_d    = FORWARD;
          sel_d      = sel_idx;
          cur_tag_d  = next_tag_q;
          next_tag_d = (next_tag_q == TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1)) ?
                       '0 : next_tag_q + 1'b1;
          rr_ptr_d   = (sel_idx == RR_W'(N_CORES - 1)) ? '0 : sel_idx + 1'b1;
        end
      end
      FORWARD: begin
        // join: each side's valid waits on the other side's ready
        in_rdy  = bus.buf_TREADY && sel_rdy;
        buf_vld = bus.in_TVALID && sel_rdy;
        if (bus.in_TVALID && bus.buf_TREADY) core_vld = N_CORES'(1) << sel_q;
        xfer = bus.in_TVALID && in_rdy;
`ifdef FORWARDER_TRUNCATE_EN
        trunc = (beat_cnt_q == BC_W'(MAX_TDATA_PER_PACKET - 1));
        if (xfer) begin
          if (bus.in_TLAST) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else if (trunc) begin
            state_d    = DROP;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
`else
        if (xfer && bus.in_TLAST) state_d = IDLE;
`endif
      end
`ifdef FORWARDER_TRUNCATE_EN
      DROP: begin
        in_rdy = 1'b1;
        if (bus.in_TVALID && bus.in_TLAST) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    case ({alloc, retire})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_tag_q     <= '0;
      next_tag_q    <= '0;
      rr_ptr_q      <= '0;
      sel_q         <= '0;
      outstanding_q <= '0;
`ifdef FORWARDER_TRUNCATE_EN
      beat_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_tag_q     <= cur_tag_d;
      next_tag_q    <= next_tag_d;
      rr_ptr_q      <= rr_ptr_d;
      sel_q         <= sel_d;
      outstanding_q <= outstanding_d;
`ifdef FORWARDER_TRUNCATE_EN
      beat_cnt_q    <= beat_cnt_d;
`endif
    end
  end

  // TLAST is masked outside FORWARD so it is 0 whenever no beat is offered
  logic tlast_out;
  assign tlast_out = (state_q == FORWARD) && (bus.in_TLAST || trunc);

  assign bus.in_TREADY        = in_rdy;
  assign bus.buf_TDATA        = bus.in_TDATA;
  assign bus.buf_TKEEP        = bus.in_TKEEP;
  assign bus.buf_TLAST        = tlast_out;
  assign bus.buf_TVALID       = buf_vld;
  assign bus.buf_reorder_tag  = cur_tag_q;
  assign bus.core_TDATA       = bus.in_TDATA;
  assign bus.core_TKEEP       = bus.in_TKEEP;
  assign bus.core_TLAST       = tlast_out;
  assign bus.core_reorder_tag = cur_tag_q;
  assign bus.core_TVALID      = core_vld;
  assign outstanding          = outstanding_q;
endmodule

// File: tb/tb_reorder_tag_forwarder.sv
// Scoreboard bench for reorder_tag_forwarder: driver queues expected beats,
// a negedge monitor checks every buffer/core transfer against them.
module tb_reorder_tag_forwarder;
  localparam int TW   = 6;
  localparam int SIZE = 50;
  localparam int DW   = 64;
  localparam int NC   = 4;
  localparam int MAXB = 8;
  localparam int OW   = $clog2(SIZE + 1);

  typedef struct {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] keep;
    logic [TW-1:0]   tag;
    logic [NC-1:0]   core;
    logic            last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tag_retire = 1'b0;
  logic [OW-1:0] outstanding;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  exp_t          sb[$];
  exp_t          mon_e;

  reorder_tag_forwarder_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .N_CORES(NC)) bus ();

  reorder_tag_forwarder #(
    .TAG_WIDTH(TW), .CIRCULAR_BUFFER_SIZE(SIZE), .DATA_WIDTH(DW),
    .N_CORES(NC), .MAX_TDATA_PER_PACKET(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tag_retire(tag_retire), .outstanding(outstanding)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every buffer transfer must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.buf_TVALID && bus.buf_TREADY) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat data=%0h tag=%0d", bus.buf_TDATA, bus.buf_reorder_tag);
        end else begin
          mon_e = sb.pop_front();
          chk("buf_data",  bus.buf_TDATA,         mon_e.data);
          chk("core_data", bus.core_TDATA,        mon_e.data);
          chk("buf_keep",  bus.buf_TKEEP,         mon_e.keep);
          chk("buf_tag",   bus.buf_reorder_tag,   mon_e.tag);
          chk("core_tag",  bus.core_reorder_tag,  mon_e.tag);
          chk("core_sel",  bus.core_TVALID,       mon_e.core);
          chk("buf_last",  bus.buf_TLAST,         mon_e.last);
          chk("core_last", bus.core_TLAST,        mon_e.last);
        end
      end
      if ((bus.buf_TVALID && bus.buf_TREADY) || |(bus.core_TVALID & bus.core_TREADY))
        chk("join", |(bus.core_TVALID & bus.core_TREADY), bus.buf_TVALID && bus.buf_TREADY);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_acc(input string nm);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_TREADY;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_accept expected=accept", nm);
    end
  endtask

  task automatic pulse_retire();
    tag_retire = 1'b1;
    @(posedge clk); #1;
    tag_retire = 1'b0;
  endtask

  task automatic apply_reset();
    chk("sb_empty_before_reset", sb.size(), 0);
    bus.in_TVALID = 1'b0; bus.in_TLAST = 1'b0;
    bus.buf_TREADY = 1'b1; bus.core_TREADY = '1;
    tag_retire = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // n beats driven, first fwd expected downstream; optional 3-cycle stall at stall_beat
  // (kind 1: buffer not ready, kind 2: selected core not ready)
  task automatic send_pkt(input int n, input int fwd, input logic [63:0] base,
                          input int tag, input int core,
                          input int stall_beat = -1, input int stall_kind = 0);
    exp_t e;
    for (int b = 0; b < fwd; b++) begin
      e.data = base + 64'(b);
      e.keep = 8'hFF >> (b % 8);
      e.tag  = TW'(tag);
      e.core = NC'(1) << core;
      e.last = (b == fwd - 1);
      sb.push_back(e);
    end
    for (int b = 0; b < n; b++) begin
      bus.in_TVALID = 1'b1;
      bus.in_TDATA  = base + 64'(b);
      bus.in_TKEEP  = 8'hFF >> (b % 8);
      bus.in_TLAST  = (b == n - 1);
      if (b == stall_beat) begin
        if (stall_kind == 1) bus.buf_TREADY = 1'b0;
        else bus.core_TREADY[core] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_TREADY, 1'b0);
          if (stall_kind == 1) chk("stall_core_valid", bus.core_TVALID, '0);
          else chk("stall_buf_valid", bus.buf_TVALID, 1'b0);
          @(posedge clk); #1;
        end
        bus.buf_TREADY = 1'b1;
        bus.core_TREADY[core] = 1'b1;
      end
      wait_acc("beat");
    end
    bus.in_TVALID = 1'b0;
    bus.in_TLAST  = 1'b0;
  endtask

  initial begin
    int t0;
    bus.in_TDATA = '0; bus.in_TKEEP = '0; bus.in_TLAST = 1'b0; bus.in_TVALID = 1'b0;
    bus.buf_TREADY = 1'b1; bus.core_TREADY = '1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",    bus.in_TREADY, 1'b0);
    chk("rst_buf_valid",   bus.buf_TVALID, 1'b0);
    chk("rst_core_valid",  bus.core_TVALID, '0);
    chk("rst_buf_last",    bus.buf_TLAST, 1'b0);
    chk("rst_core_last",   bus.core_TLAST, 1'b0);
    chk("rst_buf_tag",     bus.buf_reorder_tag, '0);
    chk("rst_core_tag",    bus.core_reorder_tag, '0);
    chk("rst_outstanding", outstanding, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // three back-to-back 4-beat packets: 1 bubble + 4 beats each
    t0 = cyc;
    for (int p = 0; p < 3; p++) send_pkt(4, 4, 64'h1000 + 64'(p * 16), p, p);
    chk("three_pkt_cycles", cyc - t0, 15);
    chk("outstanding_3", outstanding, 3);
    repeat (3) pulse_retire();
    chk("outstanding_0", outstanding, 0);
    pulse_retire();
    chk("retire_saturate", outstanding, 0);

    // tag wrap with a retire after every packet
    apply_reset();
    for (int p = 0; p < 51; p++) begin
      send_pkt(1, 1, 64'h2000 + 64'(p), p % SIZE, p % NC);
      chk("wrap_outstanding_1", outstanding, 1);
      pulse_retire();
    end
    chk("wrap_outstanding_end", outstanding, 0);

    // credit stall: fill all slots, 51st packet waits for a retire
    apply_reset();
    for (int p = 0; p < SIZE; p++) send_pkt(1, 1, 64'h3000 + 64'(p), p, p % NC);
    chk("credit_full", outstanding, SIZE);
    begin
      exp_t e;
      e.data = 64'h3FFF; e.keep = 8'hFF; e.tag = '0; e.core = 4'b0100; e.last = 1'b1;
      sb.push_back(e);
      bus.in_TVALID = 1'b1; bus.in_TDATA = 64'h3FFF; bus.in_TKEEP = 8'hFF; bus.in_TLAST = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("credit_stall_ready", bus.in_TREADY, 1'b0);
        chk("credit_stall_bufv",  bus.buf_TVALID, 1'b0);
        @(posedge clk); #1;
      end
      pulse_retire();
      chk("credit_after_retire", outstanding, SIZE - 1);
      wait_acc("credit_beat");
      bus.in_TVALID = 1'b0; bus.in_TLAST = 1'b0;
      chk("credit_refull", outstanding, SIZE);
      pulse_retire();
      // allocation and retire on the same edge
      e.data = 64'h3ABC; e.tag = 6'd1; e.core = 4'b1000;
      sb.push_back(e);
      bus.in_TVALID = 1'b1; bus.in_TDATA = 64'h3ABC; bus.in_TLAST = 1'b1;
      tag_retire = 1'b1;
      @(posedge clk); #1;
      tag_retire = 1'b0;
      chk("alloc_and_retire", outstanding, SIZE - 1);
      wait_acc("same_cycle_beat");
      bus.in_TVALID = 1'b0; bus.in_TLAST = 1'b0;
    end

    // join backpressure on buffer side, then on the selected core
    apply_reset();
    send_pkt(6, 6, 64'h4000, 0, 0, 2, 1);
    send_pkt(6, 6, 64'h4100, 1, 1, 3, 2);

    // round-robin skip over unready cores
    apply_reset();
    bus.core_TREADY = 4'b1010;
    send_pkt(1, 1, 64'h5000, 0, 1);
    send_pkt(1, 1, 64'h5001, 1, 3);
    send_pkt(1, 1, 64'h5002, 2, 1);
    bus.core_TREADY = '1;

    // over-length packet: capped with truncation, whole otherwise
    apply_reset();
`ifdef FORWARDER_TRUNCATE_EN
    send_pkt(12, MAXB, 64'h6000, 0, 0);
`else
    send_pkt(12, 12, 64'h6000, 0, 0);
`endif
    send_pkt(2, 2, 64'h6100, 1, 1);
    chk("final_outstanding", outstanding, 2);
    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
